cpu_multicycle_ctrl: RTL and testbench
======================================

Name: cpu_multicycle_ctrl

Overview:
- Multicycle control FSM for the 18-bit CPU datapath.
- Sequences fetch, decode, execute, memory and writeback for one instruction at a time.
- Drives register-file, ALU, PC, memory and immediate-path selects; the 6-bit immediate is sign-extended to 18 bits in the datapath and used when alu_src_imm=1 or pc_src=BRANCH.
- Handshakes with unified memory via mem_req/mem_ready and counts retired instructions.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- instr  in  18  IR contents: opcode[17:14], rd[13:10], rs[9:6], imm6[5:0]; valid from DECODE onward
- alu_zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes the current request this cycle
- ir_load  out  1  latch memory read data into IR
- pc_load  out  1  update PC
- pc_src  out  2  0=PC+1, 1=BRANCH (PC+sext(imm6)), 2=JUMP ({6'b0,rd,rs,imm6}'s low 12 bits, zero-extended)
- alu_op  out  2  0=ADD, 1=SUB, 2=PASS_B
- alu_src_imm  out  1  ALU B operand = sext(imm6)
- mem_req  out  1  memory request
- mem_we  out  1  memory write (only with mem_req)
- addr_sel  out  1  0=PC, 1=ALU result
- reg_we  out  1  register-file write enable
- wb_sel  out  1  0=ALU result, 1=memory data
- halted  out  1  FSM in HALT
- illegal  out  1  one-cycle pulse on undefined opcode
- state  out  3  FSM state, for debug
- retired  out  CNT_W  retired-instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Opcodes:
  - ADD=0000, SUB=0001, ADDI=0010
  - LD=0011, ST=0100
  - BEQ=0101, JMP=0110
  - HALT=1111
  - all others are illegal.
- Reset: on a clk edge with reset=1, next state=FETCH, op_q=0, retired=0, illegal=0. Reset overrides every other event, including one in mid-handshake.
- Output timing: all control outputs are combinational from state and op_q (Moore); illegal and retired are registered. Outputs not listed for a state are 0.
- FETCH:
  - mem_req=1, addr_sel=0.
  - When mem_ready=1: ir_load=1, pc_load=1, pc_src=0, and the next state is DECODE.
  - Otherwise stay in FETCH, holding outputs.
- DECODE:
  - Capture op_q<=instr[17:14].
  - HALT goes to HALT.
  - An illegal opcode goes to FETCH, with illegal=1 for the next cycle; retired does not increment.
  - Any other opcode goes to EXEC.
- EXEC:
  - ADD/SUB: alu_op=ADD/SUB, alu_src_imm=0; next state WB.
  - ADDI, LD, ST: alu_op=ADD, alu_src_imm=1; ADDI goes to WB, LD/ST go to MEM.
  - BEQ: alu_op=SUB, alu_src_imm=0. If alu_zero=1, pc_load=1 with pc_src=1. Next state FETCH, retired+1.
  - JMP: pc_load=1, pc_src=2; next state FETCH, retired+1.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=(op_q==ST).
  - Wait for mem_ready.
  - LD then goes to WB; ST goes to FETCH with retired+1.
- WB:
  - reg_we=1, wb_sel=(op_q==LD).
  - Next state FETCH, retired+1.
- HALT: halted=1. The FSM stays in HALT until reset, and all other outputs are 0.
- Latency with mem_ready held at 1:
  - ADD/SUB/ADDI: 4 cycles
  - LD: 5 cycles
  - ST: 4 cycles
  - BEQ/JMP: 3 cycles
  - Every memory stall adds 1 cycle per cycle that mem_ready=0.
- retired wraps from 2^CNT_W-1 to 0.
- mem_ready is ignored outside FETCH and MEM.

Test Plan:
- Reset with mem_ready=1, instr=ADDI rd=1 rs=0 imm6=6'b111110 → FETCH(mem_req=1) → DECODE → EXEC(alu_src_imm=1, alu_op=0) → WB(reg_we=1, wb_sel=0) → FETCH; retired=1 after 4 cycles.
- LD with mem_ready low for 3 cycles in MEM → MEM is held 4 cycles with mem_req=1, addr_sel=1, mem_we=0; then WB with wb_sel=1; 8 cycles total.
- BEQ with alu_zero=1 → EXEC has pc_load=1, pc_src=1; with alu_zero=0 → pc_load=0; both cases give retired+1 and FETCH next.
- Opcode 1010 → illegal=1 for exactly one cycle; FETCH follows DECODE directly; retired unchanged.
- HALT opcode → halted=1, which holds for 20 cycles regardless of mem_ready; reset → state=0, halted=0.
- Reset asserted during a MEM stall of an ST → next state FETCH, mem_we=0, retired=0; set retired to 16'hFFFF via 65535 retirements (or force), then one more retirement → 0.

Source files
------------

// File: rtl/cpu_multicycle_ctrl.sv
// Multicycle control FSM for the 18-bit CPU: sequences fetch/decode/execute/
// memory/writeback for one instruction at a time and counts retired instructions.
module cpu_multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [17:0]      instr,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             ir_load,
    output logic             pc_load,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic             alu_src_imm,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             halted,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_ADDI = 4'b0010;
    localparam logic [3:0] OP_LD   = 4'b0011;
    localparam logic [3:0] OP_ST   = 4'b0100;
    localparam logic [3:0] OP_BEQ  = 4'b0101;
    localparam logic [3:0] OP_JMP  = 4'b0110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] PC_INC    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    // Only the opcode field steers control; the operand fields feed the datapath.
    logic unused_operand_bits;
    assign unused_operand_bits = ^instr[13:0];

    function automatic logic is_defined(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) || (op == OP_LD) ||
               (op == OP_ST)  || (op == OP_BEQ) || (op == OP_JMP)  || (op == OP_HALT);
    endfunction

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        illegal_d   = 1'b0;
        retire      = 1'b0;
        ir_load     = 1'b0;
        pc_load     = 1'b0;
        pc_src      = PC_INC;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 1'b0;
        halted      = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_load = 1'b1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                // op_q is not valid until after this edge, so decide from instr.
                op_d = instr[17:14];
                if (instr[17:14] == OP_HALT) begin
                    state_d = S_HALT;
                end else if (!is_defined(instr[17:14])) begin
                    state_d   = S_FETCH;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        alu_op  = ALU_ADD;
                        state_d = S_WB;
                    end
                    OP_SUB: begin
                        alu_op  = ALU_SUB;
                        state_d = S_WB;
                    end
                    OP_ADDI: begin
                        alu_src_imm = 1'b1;
                        state_d     = S_WB;
                    end
                    OP_LD, OP_ST: begin
                        alu_src_imm = 1'b1;
                        state_d     = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op = ALU_SUB;
                        if (alu_zero) begin
                            pc_load = 1'b1;
                            pc_src  = PC_BRANCH;
                        end
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_load = 1'b1;
                        pc_src  = PC_JUMP;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (op_q == OP_ST);
                if (mem_ready) begin
                    if (op_q == OP_ST) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                reg_we  = 1'b1;
                wb_sel  = (op_q == OP_LD);
                retire  = 1'b1;
                state_d = S_FETCH;
            end

            S_HALT: halted = 1'b1;

            default: state_d = S_FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= 4'b0000;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            if (retire) begin
                retired_q <= retired_q + CNT_ONE;
            end
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_cpu_multicycle_ctrl.sv
// Bench for cpu_multicycle_ctrl: directed and randomized instructions checked
// against an instruction-level schedule of expected per-cycle control outputs.
module tb_cpu_multicycle_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       ir_load;
        logic       pc_load;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       alu_src_imm;
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       reg_we;
        logic       wb_sel;
        logic       halted;
    } ctrl_t;

    logic        clk;
    logic        reset;
    logic [17:0] instr;
    logic        alu_zero;
    logic        mem_ready;

    logic        ir_load, pc_load, alu_src_imm, mem_req, mem_we, addr_sel;
    logic        reg_we, wb_sel, halted, illegal;
    logic [1:0]  pc_src, alu_op;
    logic [2:0]  state;
    logic [15:0] retired;

    logic        s_ir_load, s_pc_load, s_alu_src_imm, s_mem_req, s_mem_we, s_addr_sel;
    logic        s_reg_we, s_wb_sel, s_halted, s_illegal;
    logic [1:0]  s_pc_src, s_alu_op;
    logic [2:0]  s_state;
    logic [3:0]  s_retired;

    int          n_cmp;
    int          n_fail;
    logic [15:0] exp_retired;
    logic        exp_illegal;

    cpu_multicycle_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .ir_load(ir_load), .pc_load(pc_load), .pc_src(pc_src), .alu_op(alu_op),
        .alu_src_imm(alu_src_imm), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .reg_we(reg_we), .wb_sel(wb_sel), .halted(halted), .illegal(illegal),
        .state(state), .retired(retired)
    );

    // Narrow-counter copy so wrap-around is reached in a short run.
    cpu_multicycle_ctrl #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .ir_load(s_ir_load), .pc_load(s_pc_load), .pc_src(s_pc_src), .alu_op(s_alu_op),
        .alu_src_imm(s_alu_src_imm), .mem_req(s_mem_req), .mem_we(s_mem_we),
        .addr_sel(s_addr_sel), .reg_we(s_reg_we), .wb_sel(s_wb_sel), .halted(s_halted),
        .illegal(s_illegal), .state(s_state), .retired(s_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctrl_t mk(input logic [2:0] st);
        ctrl_t c;
        c    = '0;
        c.st = st;
        return c;
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return (op <= 4'd6) || (op == 4'hF);
    endfunction

    task automatic step(input logic rst_v, input logic rdy, input logic zero,
                        input logic [17:0] ins, input ctrl_t exp_c, input string tag);
        ctrl_t obs;
        @(negedge clk);
        reset     = rst_v;
        mem_ready = rdy;
        alu_zero  = zero;
        instr     = ins;
        #1;
        obs = {state, ir_load, pc_load, pc_src, alu_op, alu_src_imm, mem_req, mem_we,
               addr_sel, reg_we, wb_sel, halted};
        n_cmp++;
        assert (obs === exp_c) else begin
            n_fail++;
            $error("FAIL %s ctrl: observed %h expected %h", tag, obs, exp_c);
        end
        n_cmp++;
        assert (illegal === exp_illegal) else begin
            n_fail++;
            $error("FAIL %s illegal: observed %b expected %b", tag, illegal, exp_illegal);
        end
        n_cmp++;
        assert (retired === exp_retired) else begin
            n_fail++;
            $error("FAIL %s retired: observed %0d expected %0d", tag, retired, exp_retired);
        end
        n_cmp++;
        assert ({s_state, s_retired} === {exp_c.st, exp_retired[3:0]}) else begin
            n_fail++;
            $error("FAIL %s small: observed %h expected %h", tag, {s_state, s_retired},
                   {exp_c.st, exp_retired[3:0]});
        end
        exp_illegal = 1'b0;
    endtask

    // Walks one instruction through its expected cycle schedule. rst_at selects a
    // MEM stall cycle in which reset is asserted (-1 for none).
    task automatic run_instr(input logic [3:0] op, input int fst, input int mst,
                             input logic zero, input int rst_at);
        logic [17:0] ins;
        ctrl_t       c;
        ins = {op, 14'($urandom)};

        c         = mk(3'd0);
        c.mem_req = 1'b1;
        for (int i = 0; i < fst; i++)
            step(1'b0, 1'b0, 1'($urandom), 18'($urandom), c, "fetch_wait");
        c.ir_load = 1'b1;
        c.pc_load = 1'b1;
        step(1'b0, 1'b1, 1'($urandom), 18'($urandom), c, "fetch");

        step(1'b0, 1'($urandom), 1'($urandom), ins, mk(3'd1), "decode");
        if (op == 4'hF) return;
        if (!is_legal(op)) begin
            exp_illegal = 1'b1;
            return;
        end

        c = mk(3'd2);
        case (op)
            4'd1:       c.alu_op = 2'd1;
            4'd2, 4'd3,
            4'd4:       c.alu_src_imm = 1'b1;
            4'd5: begin
                c.alu_op  = 2'd1;
                c.pc_load = zero;
                c.pc_src  = zero ? 2'd1 : 2'd0;
            end
            4'd6: begin
                c.pc_load = 1'b1;
                c.pc_src  = 2'd2;
            end
            default: c = mk(3'd2);
        endcase
        step(1'b0, 1'($urandom), (op == 4'd5) ? zero : 1'($urandom), ins, c, "exec");

        if (op == 4'd3 || op == 4'd4) begin
            c          = mk(3'd3);
            c.mem_req  = 1'b1;
            c.addr_sel = 1'b1;
            c.mem_we   = (op == 4'd4);
            for (int i = 0; i < mst; i++) begin
                if (i == rst_at) begin
                    step(1'b1, 1'b0, 1'($urandom), ins, c, "mem_reset");
                    exp_retired = '0;
                    return;
                end
                step(1'b0, 1'b0, 1'($urandom), ins, c, "mem_wait");
            end
            step(1'b0, 1'b1, 1'($urandom), ins, c, "mem");
        end

        if (op <= 4'd3) begin
            c        = mk(3'd4);
            c.reg_we = 1'b1;
            c.wb_sel = (op == 4'd3);
            step(1'b0, 1'($urandom), 1'($urandom), ins, c, "wb");
        end
        exp_retired = exp_retired + 16'd1;
    endtask

    initial begin
        ctrl_t c;
        logic [3:0] op;
        n_cmp       = 0;
        n_fail      = 0;
        exp_retired = '0;
        exp_illegal = 1'b0;
        reset       = 1'b1;
        mem_ready   = 1'b1;
        alu_zero    = 1'b0;
        instr       = '0;
        repeat (2) @(posedge clk);

        // ADDI rd=1 rs=0 imm=-2, no stalls: four cycles then retired=1.
        run_instr(4'd2, 0, 0, 1'b0, -1);
        // LD with three MEM stalls, then ADD/SUB and ST.
        run_instr(4'd3, 0, 3, 1'b0, -1);
        run_instr(4'd0, 1, 0, 1'b0, -1);
        run_instr(4'd1, 0, 0, 1'b0, -1);
        run_instr(4'd4, 2, 1, 1'b0, -1);
        // BEQ taken and not taken, then JMP.
        run_instr(4'd5, 0, 0, 1'b1, -1);
        run_instr(4'd5, 0, 0, 1'b0, -1);
        run_instr(4'd6, 0, 0, 1'b0, -1);
        // Undefined opcode: one-cycle illegal pulse, straight back to FETCH.
        run_instr(4'b1010, 0, 0, 1'b0, -1);
        run_instr(4'd0, 0, 0, 1'b0, -1);

        // HALT holds for 20 cycles regardless of mem_ready, until reset.
        run_instr(4'hF, 0, 0, 1'b0, -1);
        c        = mk(3'd5);
        c.halted = 1'b1;
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'($urandom), 1'($urandom), 18'($urandom), c, "halt");
        step(1'b1, 1'b1, 1'b0, 18'($urandom), c, "halt_reset");
        exp_retired = '0;

        // Reset in the middle of an ST memory stall.
        run_instr(4'd4, 0, 3, 1'b0, 1);
        run_instr(4'd3, 0, 0, 1'b0, -1);

        // Random instruction stream; the 4-bit copy wraps many times.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                7:       op = 4'd7 + 4'($urandom_range(0, 7));
                8:       op = 4'd5;
                default: op = 4'($urandom_range(0, 6));
            endcase
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
